icache: RTL and testbench

Direct-mapped instruction cache sitting between the fetch stage and its fetch requests. It answers fetch lookups within the same cycle with a hit flag and the cached instruction word. It accepts one-word fills from the fetch stage after the stage assembles an instruction from four memory-controller bytes. It also supports a single-cycle flush and keeps saturating hit/miss counters for performance reporting.

---
 rtl/icache.sv | 109 ++++++++++
 tb/tb_icache.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-entry instruction cache
// Combinational lookup with same-cycle fill bypass, single-cycle flush, saturating hit/miss counters.
module icache #(
   parameter int INDEX_BITS = 7,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 read_i,
   input  logic [31:0]          read_addr_i,
   input  logic                 write_i,
   input  logic [31:0]          write_addr_i,
   input  logic [31:0]          write_inst_i,
   input  logic                 flush_i,
   output logic                 read_hit_o,
   output logic [31:0]          read_inst_o,
   output logic [CNT_WIDTH-1:0] hit_count_o,
   output logic [CNT_WIDTH-1:0] miss_count_o
);

   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;

   logic [ENTRIES-1:0]  valid_q, valid_d;
   logic [TAG_BITS-1:0] tag_q  [ENTRIES];
   logic [31:0]         data_q [ENTRIES];

   logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
   logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

   logic [INDEX_BITS-1:0] rd_idx, wr_idx;
   logic [TAG_BITS-1:0]   rd_tag, wr_tag;
   logic                  stored_hit, bypass_hit;
   logic                  unused_addr_bits;

   assign rd_idx = read_addr_i[INDEX_BITS+1:2];
   assign rd_tag = read_addr_i[31:INDEX_BITS+2];
   assign wr_idx = write_addr_i[INDEX_BITS+1:2];
   assign wr_tag = write_addr_i[31:INDEX_BITS+2];

   // Byte offset is ignored: fetch addresses are word-aligned.
   assign unused_addr_bits = ^{read_addr_i[1:0], write_addr_i[1:0]};

   // Stored-state lookup sees pre-edge contents; a same-cycle fill only shows via the bypass.
   assign stored_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign bypass_hit = write_i && (write_addr_i[31:2] == read_addr_i[31:2]);

   always_comb begin
      read_hit_o  = 1'b0;
      read_inst_o = 32'h0;
      if (read_i) begin
         if (bypass_hit) begin
            read_hit_o  = 1'b1;
            read_inst_o = write_inst_i;
         end else if (stored_hit) begin
            read_hit_o  = 1'b1;
            read_inst_o = data_q[rd_idx];
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      if (write_i) begin
         valid_d[wr_idx] = 1'b1;
      end
      if (flush_i) begin
         valid_d = '0;
      end
   end

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (read_i) begin
         if (read_hit_o) begin
            if (hit_cnt_q != {CNT_WIDTH{1'b1}}) begin
               hit_cnt_d = hit_cnt_q + 1'b1;
            end
         end else if (miss_cnt_q != {CNT_WIDTH{1'b1}}) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q    <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         valid_q    <= valid_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   // Tag and data arrays carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (write_i) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= write_inst_i;
      end
   end

   assign hit_count_o  = hit_cnt_q;
   assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard bench for icache
// Stimulus pushes expected lookups/counter values; a negedge monitor pops and compares.
module tb_icache;

   localparam int CW = 4;

   logic          clk;
   logic          rst;
   logic          read_i;
   logic [31:0]   read_addr_i;
   logic          write_i;
   logic [31:0]   write_addr_i;
   logic [31:0]   write_inst_i;
   logic          flush_i;
   logic          read_hit_o;
   logic [31:0]   read_inst_o;
   logic [CW-1:0] hit_count_o;
   logic [CW-1:0] miss_count_o;

   icache #(.INDEX_BITS(7), .CNT_WIDTH(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .read_i       (read_i),
      .read_addr_i  (read_addr_i),
      .write_i      (write_i),
      .write_addr_i (write_addr_i),
      .write_inst_i (write_inst_i),
      .flush_i      (flush_i),
      .read_hit_o   (read_hit_o),
      .read_inst_o  (read_inst_o),
      .hit_count_o  (hit_count_o),
      .miss_count_o (miss_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        hit;
      logic [31:0] inst;
   } rd_exp_t;

   rd_exp_t       rd_q[$];
   logic [CW-1:0] hit_q[$];
   logic [CW-1:0] miss_q[$];
   logic          cnt_chk;
   int            n_vec;
   int            n_bad;

   always @(negedge clk) begin
      if (read_i) begin
         if (rd_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL lookup_unexpected addr=%h", read_addr_i);
         end else begin
            rd_exp_t e;
            e = rd_q.pop_front();
            n_vec++;
            if (read_hit_o !== e.hit || read_inst_o !== e.inst) begin
               n_bad++;
               $display("FAIL lookup addr=%h got hit=%b inst=%h want hit=%b inst=%h",
                        read_addr_i, read_hit_o, read_inst_o, e.hit, e.inst);
            end
         end
      end
      if (cnt_chk) begin
         logic [CW-1:0] eh, em;
         eh = hit_q.pop_front();
         em = miss_q.pop_front();
         n_vec++;
         if (hit_count_o !== eh || miss_count_o !== em) begin
            n_bad++;
            $display("FAIL counters got hit=%0d miss=%0d want hit=%0d miss=%0d",
                     hit_count_o, miss_count_o, eh, em);
         end
      end
   end

   task automatic expect_cnt(input logic [CW-1:0] h, input logic [CW-1:0] m);
      hit_q.push_back(h);
      miss_q.push_back(m);
      cnt_chk = 1'b1;
   endtask

   // Drive one cycle after a posedge, queue the expected lookup, then advance past the next edge.
   task automatic cycle(input logic rd, input logic [31:0] ra,
                        input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                        input logic fl, input logic eh, input logic [31:0] ei);
      rd_exp_t e;
      read_i       = rd;
      read_addr_i  = ra;
      write_i      = wr;
      write_addr_i = wa;
      write_inst_i = wd;
      flush_i      = fl;
      if (rd) begin
         e.hit  = eh;
         e.inst = ei;
         rd_q.push_back(e);
      end
      @(posedge clk);
      #1;
      cnt_chk = 1'b0;
   endtask

   task automatic idle();
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic rd(input logic [31:0] a, input logic eh, input logic [31:0] ei);
      cycle(1'b1, a, 1'b0, 32'h0, 32'h0, 1'b0, eh, ei);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      cycle(1'b0, 32'h0, 1'b1, a, d, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      n_vec        = 0;
      n_bad        = 0;
      cnt_chk      = 1'b0;
      rst          = 1'b0;
      read_i       = 1'b0;
      read_addr_i  = 32'h0;
      write_i      = 1'b0;
      write_addr_i = 32'h0;
      write_inst_i = 32'h0;
      flush_i      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      // cold miss, then fill and hit
      expect_cnt(0, 0);
      rd(32'h0000_0000, 1'b0, 32'h0);
      expect_cnt(0, 1);
      wr(32'h0000_0010, 32'h0041_0113);
      rd(32'h0000_0010, 1'b1, 32'h0041_0113);
      // bypass hit then stored hit
      expect_cnt(1, 1);
      cycle(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0020, 32'h00A0_0093, 1'b0, 1'b1, 32'h00A0_0093);
      rd(32'h0000_0020, 1'b1, 32'h00A0_0093);
      // conflicting fill at index 1; same-cycle read of old tag keeps old data
      wr(32'h0000_0004, 32'h1111_1111);
      cycle(1'b1, 32'h0000_0004, 1'b1, 32'h0000_0204, 32'h2222_2222, 1'b0, 1'b1, 32'h1111_1111);
      rd(32'h0000_0004, 1'b0, 32'h0);
      rd(32'h0000_0204, 1'b1, 32'h2222_2222);
      // flush: read in flush cycle sees old contents, later reads miss
      expect_cnt(5, 2);
      wr(32'h0000_0008, 32'h3333_3333);
      cycle(1'b1, 32'h0000_0008, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h3333_3333);
      rd(32'h0000_0008, 1'b0, 32'h0);
      rd(32'h0000_0204, 1'b0, 32'h0);
      // flush wins over same-cycle write
      cycle(1'b0, 32'h0, 1'b1, 32'h0000_0030, 32'h4444_4444, 1'b1, 1'b0, 32'h0);
      rd(32'h0000_0030, 1'b0, 32'h0);
      // bypass ignores byte offset
      expect_cnt(6, 5);
      cycle(1'b1, 32'h0000_0042, 1'b1, 32'h0000_0040, 32'h5555_5555, 1'b0, 1'b1, 32'h5555_5555);
      cycle(1'b1, 32'h0000_0040, 1'b1, 32'h0000_0050, 32'h6666_6666, 1'b0, 1'b1, 32'h5555_5555);
      rd(32'h0000_0050, 1'b1, 32'h6666_6666);
      expect_cnt(9, 5);
      idle();

      // asynchronous reset mid-cycle while a fill is presented
      expect_cnt(0, 0);
      read_i       = 1'b0;
      write_i      = 1'b1;
      write_addr_i = 32'h0000_0070;
      write_inst_i = 32'h7070_7070;
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      cnt_chk = 1'b0;
      write_i = 1'b0;
      rst     = 1'b1;
      rd(32'h0000_0070, 1'b0, 32'h0);
      rd(32'h0000_0040, 1'b0, 32'h0);
      rd(32'h0000_0050, 1'b0, 32'h0);

      // hit counter saturation
      expect_cnt(0, 3);
      wr(32'h0000_0060, 32'h7777_7777);
      for (int i = 0; i < 15; i++) begin
         rd(32'h0000_0060, 1'b1, 32'h7777_7777);
      end
      expect_cnt(15, 3);
      rd(32'h0000_0060, 1'b1, 32'h7777_7777);
      expect_cnt(15, 3);
      idle();
      idle();

      if (rd_q.size() != 0 || hit_q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL leftover_expectations got %0d want 0", rd_q.size() + hit_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
